// File: rtl/module_result_display.sv
`default_nettype none
// ============================================================================
//  Module      : module_result_display
//  Description : Captures an adder result (with carry) and shows it as three
//                multiplexed hex digits on a 4-digit active-low 7-segment
//                display; the carry drives an overflow LED.
//  Revision    : 1.0 - initial release
// ============================================================================
module module_result_display #(
    parameter int WIDTH         = 8,
    parameter int REFRESH_COUNT = 100000
) (
    input  logic             clk_pi,
    input  logic             rst_pi,
    input  logic [WIDTH:0]   result_pi,
    input  logic             load_pi,
    output logic [3:0]       anodo_po,
    output logic [6:0]       seg_po,
    output logic             overflow_po,
    output logic             valid_po
);

    localparam int               C_CNT_W   = $clog2(REFRESH_COUNT);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(REFRESH_COUNT - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);
    // Captured value padded so three full nibbles can always be sliced out.
    localparam int               C_PAD_W   = (WIDTH + 1 > 12) ? (WIDTH + 1) : 12;

    localparam logic [1:0] C_DIGIT0 = 2'd0;
    localparam logic [1:0] C_DIGIT1 = 2'd1;
    localparam logic [1:0] C_DIGIT2 = 2'd2;

    logic [WIDTH:0]     capture_q, capture_d;
    logic               valid_q, valid_d;
    logic [C_CNT_W-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [1:0]         digit_idx_q, digit_idx_d;

    logic               w_refresh_wrap;
    logic [C_PAD_W-1:0] w_padded;
    logic [3:0]         w_nibble;

    // Next-state logic: capture on load, free-running refresh scan.
    always_comb begin
        capture_d     = capture_q;
        valid_d       = valid_q;
        refresh_cnt_d = refresh_cnt_q + C_CNT_ONE;
        digit_idx_d   = digit_idx_q;

        if (load_pi) begin
            capture_d = result_pi;
            valid_d   = 1'b1;
        end

        // >= rather than == so an out-of-range count can never run away.
        w_refresh_wrap = (refresh_cnt_q >= C_CNT_LAST);
        if (w_refresh_wrap) begin
            refresh_cnt_d = '0;
            case (digit_idx_q)
                C_DIGIT0: digit_idx_d = C_DIGIT1;
                C_DIGIT1: digit_idx_d = C_DIGIT2;
                default:  digit_idx_d = C_DIGIT0;  // 2 -> 0, and 3 recovers to 0
            endcase
        end
    end

    // State registers with synchronous reset taking priority over load.
    always_ff @(posedge clk_pi) begin
        if (rst_pi) begin
            capture_q     <= '0;
            valid_q       <= 1'b0;
            refresh_cnt_q <= '0;
            digit_idx_q   <= C_DIGIT0;
        end else begin
            capture_q     <= capture_d;
            valid_q       <= valid_d;
            refresh_cnt_q <= refresh_cnt_d;
            digit_idx_q   <= digit_idx_d;
        end
    end

    // Digit select: anode enable and the nibble shown on that digit.
    always_comb begin
        w_padded = C_PAD_W'(capture_q);
        anodo_po = 4'b1111;
        w_nibble = 4'h0;
        case (digit_idx_q)
            C_DIGIT0: begin anodo_po = 4'b1110; w_nibble = w_padded[3:0];  end
            C_DIGIT1: begin anodo_po = 4'b1101; w_nibble = w_padded[7:4];  end
            C_DIGIT2: begin anodo_po = 4'b1011; w_nibble = w_padded[11:8]; end
            default:  begin anodo_po = 4'b1111; w_nibble = 4'h0;           end
        endcase
    end

    // Active-low hex to 7-segment decode, segment order {g,f,e,d,c,b,a}.
    always_comb begin
        case (w_nibble)
            4'h0:    seg_po = 7'b1000000;
            4'h1:    seg_po = 7'b1111001;
            4'h2:    seg_po = 7'b0100100;
            4'h3:    seg_po = 7'b0110000;
            4'h4:    seg_po = 7'b0011001;
            4'h5:    seg_po = 7'b0010010;
            4'h6:    seg_po = 7'b0000010;
            4'h7:    seg_po = 7'b1111000;
            4'h8:    seg_po = 7'b0000000;
            4'h9:    seg_po = 7'b0010000;
            4'hA:    seg_po = 7'b0001000;
            4'hB:    seg_po = 7'b0000011;
            4'hC:    seg_po = 7'b1000110;
            4'hD:    seg_po = 7'b0100001;
            4'hE:    seg_po = 7'b0000110;
            default: seg_po = 7'b0001110;
        endcase
    end

    assign overflow_po = capture_q[WIDTH];
    assign valid_po    = valid_q;

endmodule
`default_nettype wire
